// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous push/pop FIFO with a one-cycle read latency.
// It presents the words on a valid/ready stream that is framed into BURST_LEN-word bursts.
// A 2-entry prefetch buffer covers the read latency, so a sink that is always ready
// receives one word per cycle.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  pop,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_out
);

  localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e                r_state, w_state_next;
  logic [1:0]            r_count, w_count_next;
  logic                  r_head, r_tail;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic [BeatW-1:0]      r_beat;
  logic [CNT_WIDTH-1:0]  r_words;

  logic                  w_fire;
  logic                  w_wr;
  logic [2:0]            w_occ;

  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_buf[r_head];
  assign out_last  = out_valid & (r_beat == LastBeat);
  assign w_fire    = out_valid & out_ready;
  // Returning reads are dropped while flushing and on the edge that enters flush.
  assign w_wr      = r_inflight & (r_state != StFlush) & ~flush;
  // Occupancy after this cycle's fire, counting the read already in flight.
  assign w_occ     = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_fire};
  assign busy      = (r_state != StIdle) | (r_count != 2'd0) | r_inflight;
  assign words_out = r_words;
  assign w_count_next = r_count + {1'b0, w_wr} - {1'b0, w_fire};

  // Next-state and pop decode; flush overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    pop          = 1'b0;
    case (r_state)
      StIdle: begin
        if (enable) w_state_next = StRun;
      end
      StRun: begin
        pop = enable & ~fifo_empty & (w_occ < 3'd2);
        if (!enable) w_state_next = StIdle;
      end
      StFlush: begin
        pop = ~fifo_empty;
        if (fifo_empty && !r_inflight) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
    if (flush) w_state_next = StFlush;
  end

  // State, occupancy, pointers, beat and delivered-word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_inflight <= 1'b0;
      r_beat     <= '0;
      r_words    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= pop;
      // A word accepted in the flush cycle still counts as delivered.
      if (w_fire) r_words <= r_words + CNT_WIDTH'(1);
      if (flush) begin
        r_count <= 2'd0;
        r_head  <= 1'b0;
        r_tail  <= 1'b0;
        r_beat  <= '0;
      end else begin
        r_count <= w_count_next;
        if (w_fire) begin
          r_head <= ~r_head;
          r_beat <= (r_beat == LastBeat) ? '0 : r_beat + BeatW'(1);
        end
        if (w_wr) r_tail <= ~r_tail;
      end
    end
  end

  // Prefetch storage: the returning read is written at the tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
    end else if (w_wr) begin
      r_buf[r_tail] <= rd_data;
    end
  end

  // The buffer plus the outstanding read never exceed two entries.
  a_occupancy : assert property (@(posedge clk) disable iff (reset)
    (({1'b0, r_count} + {2'b0, r_inflight}) <= 3'd2));

endmodule
